// File: rtl/sm83_bus_pkg.sv
// Shared types and address map for the SM83 bus sequencer.
// Contents:
//   region_t       address region latched for the current M-cycle
//   per_sel_t      peripheral port select code (0 none, 1 VRAM, 2 OAM, 3 IO)
//   *_BASE         region start addresses
//   decode_region  combinational address -> region decode
//   is_external    region is served by the cartridge/WRAM pins
//   region_to_per  region -> peripheral select code
package sm83_bus_pkg;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_ROM,
        REG_VRAM,
        REG_ERAM,
        REG_WRAM,
        REG_OAM,
        REG_UNUSABLE,
        REG_IO,
        REG_HRAM,
        REG_IE
    } region_t;

    typedef enum logic [2:0] {
        PER_NONE = 3'd0,
        PER_VRAM = 3'd1,
        PER_OAM  = 3'd2,
        PER_IO   = 3'd3
    } per_sel_t;

    localparam logic [15:0] VRAM_BASE     = 16'h8000;
    localparam logic [15:0] ERAM_BASE     = 16'hA000;
    localparam logic [15:0] WRAM_BASE     = 16'hC000;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] UNUSABLE_BASE = 16'hFEA0;
    localparam logic [15:0] IO_BASE       = 16'hFF00;
    localparam logic [15:0] HRAM_BASE     = 16'hFF80;
    localparam logic [15:0] IE_ADDR       = 16'hFFFF;

    // Echo RAM (E000-FDFF) is folded into WRAM.
    function automatic region_t decode_region(input logic [15:0] a);
        region_t r;
        if (a < VRAM_BASE)           r = REG_ROM;
        else if (a < ERAM_BASE)      r = REG_VRAM;
        else if (a < WRAM_BASE)      r = REG_ERAM;
        else if (a < OAM_BASE)       r = REG_WRAM;
        else if (a < UNUSABLE_BASE)  r = REG_OAM;
        else if (a < IO_BASE)        r = REG_UNUSABLE;
        else if (a < HRAM_BASE)      r = REG_IO;
        else if (a != IE_ADDR)       r = REG_HRAM;
        else                         r = REG_IE;
        return r;
    endfunction

    function automatic logic is_external(input region_t r);
        return (r == REG_ROM) || (r == REG_ERAM) || (r == REG_WRAM);
    endfunction

    function automatic per_sel_t region_to_per(input region_t r);
        per_sel_t p;
        case (r)
            REG_VRAM: p = PER_VRAM;
            REG_OAM:  p = PER_OAM;
            REG_IO:   p = PER_IO;
            default:  p = PER_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sm83_bus_ctl_hram.sv
// High RAM (FF80-FFFE) storage: synchronous write, asynchronous read.
// Ports:
//   clk    clock
//   we     write enable, sampled at posedge
//   waddr  write word index (address bits [6:0])
//   wdata  write data
//   raddr  read word index
//   rdata  read data (combinational)
// Contents are deliberately not reset.
module sm83_hram #(
    parameter int WORDS = 127
) (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);

    localparam logic [6:0] LAST = 7'(WORDS - 1);

    logic [7:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST)) mem[waddr] <= wdata;
    end

    // Index 7F aliases IE and has no storage behind it.
    assign rdata = (raddr <= LAST) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/sm83_bus_ctl.sv
// SM83 bus sequencer: turns the I/O stage's rd/wr/aout/ext_dout and the
// t1..t4 phase strobes into cartridge/WRAM pin strobes, peripheral port
// strobes and HRAM accesses, and returns read data for sampling at T4.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   t1..t4                   one-hot M-cycle phase strobes
//   rd, wr                   read / write cycle in progress (T1..T4)
//   aout, ext_dout           CPU address / write data
//   ext_din                  read data to CPU (valid in T4, held after)
//   iena_sel                 read of the CPU-internal IE register (T4)
//   dma_active               OAM DMA running; blocks non-HRAM/IO/IE access
//   pin_a, pin_d_out         external address / data out (pass-through)
//   pin_d_oe                 external data drive enable
//   pin_d_in                 external data in
//   pin_rd_n/wr_n/cs_n       external strobes, active low
//   per_sel, per_rd, per_wr  peripheral port select and strobes
//   per_din                  peripheral read data
module sm83_bus_ctl
    import sm83_bus_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS   = 8'hFF,
    parameter int         HRAM_WORDS = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        t1,
    input  logic        t2,
    input  logic        t3,
    input  logic        t4,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] aout,
    input  logic [7:0]  ext_dout,
    output logic [7:0]  ext_din,
    output logic        iena_sel,
    input  logic        dma_active,
    output logic [15:0] pin_a,
    output logic [7:0]  pin_d_out,
    output logic        pin_d_oe,
    input  logic [7:0]  pin_d_in,
    output logic        pin_rd_n,
    output logic        pin_wr_n,
    output logic        pin_cs_n,
    output logic [2:0]  per_sel,
    output logic        per_rd,
    output logic        per_wr,
    input  logic [7:0]  per_din
);

    region_t    region_now;
    logic       blocked_now;
    region_t    region_q;
    logic       blocked_q;
    logic       rd_q;
    logic       wr_q;
    logic [6:0] hram_addr_q;
    logic       cs_n_q;
    logic       rd_n_q;
    logic       wr_n_q;
    logic       d_oe_q;
    per_sel_t   per_sel_q;
    logic       per_rd_q;
    logic [7:0] rdata_q;
    logic [7:0] read_mux;
    logic [7:0] hram_rdata;
    logic       hram_we;
    logic       start;

    always_comb begin
        region_now  = decode_region(aout);
        // DMA owns the bus; only the CPU-private spaces stay reachable.
        blocked_now = dma_active &&
                      !((region_now == REG_HRAM) || (region_now == REG_IE) ||
                        (region_now == REG_IO));
    end

    assign start = t1 && (rd || wr);

    always_ff @(posedge clk) begin
        if (reset) begin
            region_q  <= REG_NONE;
            blocked_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            d_oe_q    <= 1'b0;
            per_sel_q <= PER_NONE;
            per_rd_q  <= 1'b0;
            rdata_q   <= OPEN_BUS;
        end else if (start) begin
            // End T1: latch the access; later aout changes are ignored.
            region_q  <= region_now;
            blocked_q <= blocked_now;
            rd_q      <= rd;
            wr_q      <= wr;
            cs_n_q    <= !(((region_now == REG_ERAM) || (region_now == REG_WRAM)) &&
                           !blocked_now);
            rd_n_q    <= !(rd && is_external(region_now) && !blocked_now);
            d_oe_q    <= wr && is_external(region_now) && !blocked_now;
            per_sel_q <= blocked_now ? PER_NONE : region_to_per(region_now);
            per_rd_q  <= rd && !blocked_now && (region_to_per(region_now) != PER_NONE);
        end else if (t2) begin
            // End T2: write strobe spans the T3 clock only.
            wr_n_q <= !(wr_q && is_external(region_q) && !blocked_q);
        end else if (t3) begin
            // End T3: close write/peripheral-read strobes and capture read data.
            wr_n_q   <= 1'b1;
            per_rd_q <= 1'b0;
            if (rd_q && (region_q != REG_NONE)) rdata_q <= read_mux;
        end else if (t4) begin
            // End T4: return to idle.
            region_q  <= REG_NONE;
            blocked_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            d_oe_q    <= 1'b0;
            per_sel_q <= PER_NONE;
            per_rd_q  <= 1'b0;
        end
    end

    // HRAM index is data only; it is meaningful only while region_q is HRAM.
    always_ff @(posedge clk) begin
        if (start) hram_addr_q <= aout[6:0];
    end

    always_comb begin
        read_mux = OPEN_BUS;
        if (!blocked_q) begin
            case (region_q)
                REG_ROM, REG_ERAM, REG_WRAM: read_mux = pin_d_in;
                REG_VRAM, REG_OAM, REG_IO:   read_mux = per_din;
                REG_HRAM:                    read_mux = hram_rdata;
                default:                     read_mux = OPEN_BUS;
            endcase
        end
    end

    assign hram_we = wr && t4 && (region_q == REG_HRAM) && !reset;

    sm83_hram #(
        .WORDS (HRAM_WORDS)
    ) u_hram (
        .clk   (clk),
        .we    (hram_we),
        .waddr (hram_addr_q),
        .wdata (ext_dout),
        .raddr (hram_addr_q),
        .rdata (hram_rdata)
    );

    assign pin_a     = aout;
    assign pin_d_out = ext_dout;
    assign pin_d_oe  = d_oe_q;
    assign pin_rd_n  = rd_n_q;
    assign pin_wr_n  = wr_n_q;
    assign pin_cs_n  = cs_n_q;
    assign per_sel   = per_sel_q;
    assign per_rd    = per_rd_q;
    assign per_wr    = wr && t4 && (region_to_per(region_q) != PER_NONE) && !blocked_q;
    assign iena_sel  = rd && t4 && (region_q == REG_IE);
    assign ext_din   = rdata_q;

endmodule

// File: tb/tb_sm83_bus_ctl.sv
module tb_sm83_bus_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        t1, t2, t3, t4;
    logic        rd, wr;
    logic [15:0] aout;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din;
    logic        iena_sel;
    logic        dma_active;
    logic [15:0] pin_a;
    logic [7:0]  pin_d_out;
    logic        pin_d_oe;
    logic [7:0]  pin_d_in;
    logic        pin_rd_n, pin_wr_n, pin_cs_n;
    logic [2:0]  per_sel;
    logic        per_rd, per_wr;
    logic [7:0]  per_din;

    always #5 clk = ~clk;

    sm83_bus_ctl dut (
        .clk        (clk),
        .reset      (reset),
        .t1         (t1),
        .t2         (t2),
        .t3         (t3),
        .t4         (t4),
        .rd         (rd),
        .wr         (wr),
        .aout       (aout),
        .ext_dout   (ext_dout),
        .ext_din    (ext_din),
        .iena_sel   (iena_sel),
        .dma_active (dma_active),
        .pin_a      (pin_a),
        .pin_d_out  (pin_d_out),
        .pin_d_oe   (pin_d_oe),
        .pin_d_in   (pin_d_in),
        .pin_rd_n   (pin_rd_n),
        .pin_wr_n   (pin_wr_n),
        .pin_cs_n   (pin_cs_n),
        .per_sel    (per_sel),
        .per_rd     (per_rd),
        .per_wr     (per_wr),
        .per_din    (per_din)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: HRAM image and the value ext_din should be holding.
    logic [7:0] hmem [0:126];
    bit         hval [0:126];
    logic [7:0] exp_din;
    bit         din_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string where);
        check({where, ".cs_n"},  32'(pin_cs_n), 32'd1);
        check({where, ".rd_n"},  32'(pin_rd_n), 32'd1);
        check({where, ".wr_n"},  32'(pin_wr_n), 32'd1);
        check({where, ".d_oe"},  32'(pin_d_oe), 32'd0);
        check({where, ".psel"},  32'(per_sel),  32'd0);
        check({where, ".per_rd"}, 32'(per_rd),  32'd0);
        check({where, ".per_wr"}, 32'(per_wr),  32'd0);
        check({where, ".iena"},  32'(iena_sel), 32'd0);
    endtask

    // One full M-cycle. Expectations come straight from the address map.
    task automatic txn(input logic [15:0] a, input bit w, input logic [7:0] d, input bit dma,
                       input logic [7:0] pdin, input logic [7:0] pfdin, input bit scramble);
        bit ext, cs, hr, ie, blk, go, rdknown;
        int pcode, idx;
        logic [7:0] rdexp;
        ext   = (a < 16'h8000) || (a >= 16'hA000 && a < 16'hFE00);
        cs    = (a >= 16'hA000 && a < 16'hFE00);
        pcode = (a >= 16'h8000 && a < 16'hA000) ? 1 :
                (a >= 16'hFE00 && a < 16'hFEA0) ? 2 :
                (a >= 16'hFF00 && a < 16'hFF80) ? 3 : 0;
        hr    = (a >= 16'hFF80) && (a != 16'hFFFF);
        ie    = (a == 16'hFFFF);
        blk   = dma && (a < 16'hFF00);
        go    = !blk;
        idx   = int'(a) - 'hFF80;
        rdknown = 1'b1;
        if (blk)             rdexp = 8'hFF;
        else if (ext)        rdexp = pdin;
        else if (pcode != 0) rdexp = pfdin;
        else if (hr) begin   rdexp = hmem[idx]; rdknown = hval[idx]; end
        else if (ie) begin   rdexp = 8'hFF; rdknown = 1'b0; end
        else                 rdexp = 8'hFF;

        for (int p = 1; p <= 4; p++) begin
            @(negedge clk);
            t1 = (p == 1); t2 = (p == 2); t3 = (p == 3); t4 = (p == 4);
            rd = !w; wr = w;
            ext_dout = d; dma_active = dma; pin_d_in = pdin; per_din = pfdin;
            aout = (scramble && p > 1) ? 16'($urandom) : a;
            #1;
            check("pin_a",     32'(pin_a),     32'(aout));
            check("pin_d_out", 32'(pin_d_out), 32'(ext_dout));
            check("cs_n",      32'(pin_cs_n),  32'(!(cs && go && p > 1)));
            check("rd_n",      32'(pin_rd_n),  32'(!(ext && go && !w && p > 1)));
            check("wr_n",      32'(pin_wr_n),  32'(!(ext && go && w && p == 3)));
            check("d_oe",      32'(pin_d_oe),  32'(ext && go && w && p > 1));
            check("per_sel",   32'(per_sel),   (go && p > 1) ? pcode : 0);
            check("per_rd",    32'(per_rd),    32'(go && pcode != 0 && !w && (p == 2 || p == 3)));
            check("per_wr",    32'(per_wr),    32'(go && pcode != 0 && w && p == 4));
            check("iena_sel",  32'(iena_sel),  32'(ie && !w && p == 4));
            if (p == 4 && !w) begin
                exp_din   = rdexp;
                din_known = rdknown;
            end
            if (din_known) check("ext_din", 32'(ext_din), 32'(exp_din));
        end

        @(negedge clk);
        t1 = 0; t2 = 0; t3 = 0; t4 = 0; rd = 0; wr = 0;
        aout = 16'($urandom);
        #1;
        check_idle("idle");
        if (din_known) check("ext_din.hold", 32'(ext_din), 32'(exp_din));
        if (w && hr) begin
            hmem[idx] = d;
            hval[idx] = 1'b1;
        end
    endtask

    // Write cycle interrupted by reset during T2.
    task automatic reset_mid(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        t1 = 1; t2 = 0; t3 = 0; t4 = 0; rd = 0; wr = 1; aout = a; ext_dout = d; dma_active = 0;
        @(negedge clk);
        t1 = 0; t2 = 1; reset = 1;
        @(negedge clk);
        t2 = 0; t3 = 1;
        #1;
        check_idle("rst_mid.t3");
        check("rst_mid.ext_din", 32'(ext_din), 32'hFF);
        reset = 0;
        @(negedge clk);
        t3 = 0; t4 = 1;
        #1;
        check("rst_mid.per_wr", 32'(per_wr), 32'd0);
        check("rst_mid.wr_n",   32'(pin_wr_n), 32'd1);
        @(negedge clk);
        t4 = 0; wr = 0;
        exp_din   = 8'hFF;
        din_known = 1'b1;
    endtask

    function automatic logic [15:0] rand_addr(input int r);
        logic [15:0] a;
        case (r)
            0:       a = 16'($urandom_range(16'h0000, 16'h7FFF));
            1:       a = 16'($urandom_range(16'h8000, 16'h9FFF));
            2:       a = 16'($urandom_range(16'hA000, 16'hBFFF));
            3:       a = 16'($urandom_range(16'hC000, 16'hFDFF));
            4:       a = 16'($urandom_range(16'hFE00, 16'hFE9F));
            5:       a = 16'($urandom_range(16'hFEA0, 16'hFEFF));
            6:       a = 16'($urandom_range(16'hFF00, 16'hFF7F));
            7:       a = 16'($urandom_range(16'hFF80, 16'hFFFE));
            default: a = 16'hFFFF;
        endcase
        return a;
    endfunction

    initial begin
        reset = 1; t1 = 0; t2 = 0; t3 = 0; t4 = 0; rd = 0; wr = 0;
        aout = 16'h1234; ext_dout = 8'h9C; dma_active = 0; pin_d_in = 0; per_din = 0;
        for (int i = 0; i < 127; i++) begin hmem[i] = 8'h00; hval[i] = 1'b0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_idle("reset");
        check("reset.ext_din",   32'(ext_din),   32'hFF);
        check("reset.pin_a",     32'(pin_a),     32'h1234);
        check("reset.pin_d_out", 32'(pin_d_out), 32'h9C);
        reset = 0;
        exp_din = 8'hFF; din_known = 1'b1;

        // Directed scenarios
        txn(16'h0150, 0, 8'h00, 0, 8'h3E, 8'h00, 0);
        txn(16'hC000, 1, 8'h5A, 0, 8'h00, 8'h00, 0);
        txn(16'hFF90, 1, 8'hA5, 0, 8'h00, 8'h00, 0);
        txn(16'hFF90, 0, 8'h00, 0, 8'h11, 8'h22, 0);
        txn(16'hFFFF, 0, 8'h00, 0, 8'h33, 8'h44, 0);
        txn(16'hC123, 0, 8'h00, 1, 8'h55, 8'h66, 0);
        txn(16'hFF85, 1, 8'h11, 1, 8'h00, 8'h00, 0);
        txn(16'hFF85, 0, 8'h00, 1, 8'h77, 8'h88, 0);
        txn(16'hFF40, 1, 8'h91, 1, 8'h00, 8'h00, 0);
        txn(16'hFF40, 0, 8'h00, 1, 8'h00, 8'hC7, 0);
        txn(16'hFEA5, 0, 8'h00, 0, 8'h12, 8'h34, 0);
        txn(16'h9800, 0, 8'h00, 1, 8'h12, 8'h34, 0);

        // Fill HRAM so later reads have known contents
        for (int i = 0; i < 127; i++)
            txn(16'hFF80 + 16'(i), 1, 8'($urandom), ($urandom_range(0, 3) == 0),
                8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));

        // Randomized traffic over all regions
        for (int n = 0; n < 400; n++)
            txn(rand_addr($urandom_range(0, 8)), bit'($urandom_range(0, 1)), 8'($urandom),
                ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
                bit'($urandom_range(0, 1)));

        // Reset in the middle of writes
        reset_mid(16'hFF80, 8'h77);
        txn(16'hFF80, 0, 8'h00, 0, 8'h00, 8'h00, 0);
        reset_mid(16'hC000, 8'h3C);
        txn(16'hC000, 0, 8'h00, 0, 8'hB2, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sm83_bus_ctl.md
Name: sm83_bus_ctl

Overview:
External/internal bus sequencer directly downstream of the SM83 I/O stage.
- Consumes rd, wr, aout and ext_dout together with the t1..t4 phase strobes.
- Decodes the address region, drives cartridge/WRAM pin strobes, the peripheral (VRAM/OAM/IO) port and internal HRAM.
- Returns read data on ext_din and raises iena_sel, both sampled by the I/O stage at T4.

Parameters:
OPEN_BUS, 8'hFF, read value for blocked or unusable accesses
HRAM_WORDS, 127, HRAM depth (FF80-FFFE)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
t1,t2,t3,t4  in  1 each  one-hot M-cycle phase strobes, one clk each
rd  in  1  read cycle in progress (high T1..T4)
wr  in  1  write cycle in progress (high T1..T4)
aout  in  16  CPU address
ext_dout  in  8  CPU write data
ext_din  out  8  read data to CPU, valid during T4
iena_sel  out  1  selects CPU-internal IE register (FFFF)
dma_active  in  1  OAM DMA running
pin_a  out  16  external address pins
pin_d_out  out  8  external data out
pin_d_oe  out  1  external data drive enable
pin_d_in  in  8  external data in
pin_rd_n, pin_wr_n, pin_cs_n  out  1 each  external strobes, active low
per_sel  out  3  peripheral select: 0 none, 1 VRAM, 2 OAM, 3 IO
per_rd  out  1  peripheral read strobe
per_wr  out  1  peripheral write strobe (single clk)
per_din  in  8  peripheral read data

Behaviour:
- Phase naming: "end Tn" is the posedge at which tn is high.
- Region decode (combinational on aout):
  - ROM 0000-7FFF
  - VRAM 8000-9FFF
  - ERAM A000-BFFF
  - WRAM C000-FDFF
  - OAM FE00-FE9F
  - UNUSABLE FEA0-FEFF
  - IO FF00-FF7F
  - HRAM FF80-FFFE
  - IE FFFF
- region_q: latched at end T1 when rd|wr; held through T4; cleared to NONE at end T4. Later aout changes within the cycle do not affect strobes.
- Blocked access: dma_active sampled at end T1 with region not in {HRAM, IE, IO}. No strobes, writes dropped, read returns OPEN_BUS.
- External regions = ROM, ERAM, WRAM. pin_a = aout continuously.
  - pin_cs_n = 0 from end T1 to end T4 for ERAM/WRAM accesses; 1 otherwise.
  - pin_rd_n = 0 from end T1 to end T4 for external reads.
  - pin_wr_n = 0 from end T2 to end T3 for external writes.
  - pin_d_oe = 1 from end T1 to end T4 for external writes; pin_d_out = ext_dout.
- Peripheral regions:
  - per_sel is registered at end T1 and cleared at end T4.
  - per_rd = 1 from end T1 to end T3 on reads.
  - per_wr = wr & t4 & peripheral region & not blocked (combinational, 1 clk).
- HRAM: sub-module storage, asynchronous read. Write at end T4 with ext_dout when wr & region_q==HRAM. Contents not cleared by reset.
- Read data: rdata_q captured at end T3 of a read from:
  - pin_d_in (external)
  - per_din (peripheral)
  - HRAM
  - OPEN_BUS (UNUSABLE/blocked)
  - IE: rdata_q don't-care
- ext_din = rdata_q; holds value between cycles.
- iena_sel = rd & t4 & region_q==IE (combinational).
- Idle (no rd/wr): all _n strobes 1, pin_d_oe 0, per_sel 0, per_rd 0, per_wr 0.
- Reset (each output):
  - pin_rd_n, pin_wr_n, pin_cs_n = 1
  - pin_d_oe = 0, pin_d_out = ext_dout (combinational)
  - per_sel = 0, per_rd = 0, per_wr = 0
  - iena_sel = 0
  - pin_a = aout (combinational)
  - ext_din (rdata_q) = OPEN_BUS
  - region_q = NONE
- Reset mid-cycle: strobes inactive next edge; no HRAM write; bench asserts rd & wr never both high.

Decomposition:
Package sm83_bus_pkg:
- region_t enum: NONE, ROM, VRAM, ERAM, WRAM, OAM, UNUSABLE, IO, HRAM, IE
- per_sel_t enum
- region boundary constants
- decode function addr→region_t
Sub-module sm83_hram:
- 127x8 array
- we, waddr[6:0], wdata, raddr, rdata (async)

Test Plan:
1. Read 0x0150, pin_d_in=0x3E → pin_rd_n low end T1..end T4, pin_cs_n stays 1, ext_din=0x3E at T4.
2. Write 0xC000=0x5A → pin_cs_n low end T1..T4, pin_wr_n low end T2..end T3 only, pin_d_oe high, pin_d_out=0x5A.
3. Write 0xFF90=0xA5 then read 0xFF90 → no pin strobes; ext_din=0xA5.
4. Read 0xFFFF → iena_sel=1 only during T4, no strobes.
5. dma_active=1: read 0xC123 → ext_din=0xFF, no strobes; write 0xFF85=0x11 → HRAM updated; write 0xFF40 → per_wr pulses at T4, per_sel=3.
6. Reset asserted in T2 of write to 0xFF80 → strobes inactive next edge, HRAM[0] unchanged, ext_din=0xFF.
